id_stage_pipe: RTL and testbench

- Parametrised instruction-decode stage with its ID/EX pipeline register built in.
- Contains the register file with write-through bypass, load-use hazard detection with bubble injection, and stall/flush handling.
- Keeps a saturating bubble counter.
- Sits between the IF/ID register and the EX stage; takes pre-decoded control from the existing control decoder and the writeback port from WB.

---
 rtl/id_stage_pipe_pkg.sv | 13 +
 rtl/id_stage_pipe_if.sv | 60 ++++++
 rtl/id_stage_pipe_regfile_bypass.sv | 44 ++++
 rtl/id_stage_pipe.sv | 150 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared constants for the ID stage: parameter defaults, the hard-wired zero register
// and instruction field positions.
package id_stage_pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REGS_DEF  = 32;
  localparam int ZERO_REG  = 0;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int SHAMT_LSB = 6;
  localparam int SHAMT_W   = 5;

endpackage

// File: rtl/id_stage_pipe_if.sv
// Bundle of the ID-stage inputs (IF/ID, decoder, WB, downstream control) and the ID/EX outputs.
// The master modport drives the ID side; the slave modport is the stage itself.
interface id_stage_pipe_if
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REGS   = REGS_DEF,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(REGS);

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [31:0]       id_inst;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_memread;
  logic              dec_regwrite;
  logic              dec_uses_rt;
  logic              dec_shift;
  logic              dec_imm_sel;
  logic [XLEN-1:0]   dec_imm;
  logic [AW-1:0]     dec_dest;
  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              ex_flush;
  logic              ext_stall;

  logic              stall;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_memread;
  logic              ex_regwrite;
  logic [AW-1:0]     ex_dest;
  logic [AW-1:0]     ex_rs;
  logic [AW-1:0]     ex_rt;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;
  logic [XLEN-1:0]   ex_rdata2;
  logic [XLEN-1:0]   ex_pc;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_pc, id_inst, dec_ctrl, dec_memread, dec_regwrite, dec_uses_rt,
           dec_shift, dec_imm_sel, dec_imm, dec_dest, wb_we, wb_addr, wb_data,
           ex_flush, ext_stall,
    input  stall, ex_valid, ex_ctrl, ex_memread, ex_regwrite, ex_dest, ex_rs, ex_rt,
           ex_op1, ex_op2, ex_rdata2, ex_pc, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_inst, dec_ctrl, dec_memread, dec_regwrite, dec_uses_rt,
           dec_shift, dec_imm_sel, dec_imm, dec_dest, wb_we, wb_addr, wb_data,
           ex_flush, ext_stall,
    output stall, ex_valid, ex_ctrl, ex_memread, ex_regwrite, ex_dest, ex_rs, ex_rt,
           ex_op1, ex_op2, ex_rdata2, ex_pc, bubble_cnt
  );

endinterface

// File: rtl/id_stage_pipe_regfile_bypass.sv
// Two-read, one-write register file; entry 0 is hard-wired to zero and a same-cycle
// write to the addressed entry is forwarded straight to the read port.
module regfile_bypass
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGS = REGS_DEF,
  parameter int AW   = $clog2(REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] mem_q [REGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != AW'(ZERO_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    if (raddr1_i == AW'(ZERO_REG))             rdata1_o = '0;
    else if (wr_en && (waddr_i == raddr1_i))   rdata1_o = wdata_i;

    rdata2_o = mem_q[raddr2_i];
    if (raddr2_i == AW'(ZERO_REG))             rdata2_o = '0;
    else if (wr_en && (waddr_i == raddr2_i))   rdata2_o = wdata_i;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with built-in ID/EX register: operand read and formation,
// load-use bubble injection, flush/stall priority and a saturating bubble counter.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REGS   = REGS_DEF,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_stage_pipe_if.slave   bus
);

  localparam int AW = $clog2(REGS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [AW-1:0]     rs, rt;
  logic [XLEN-1:0]   rdata1, rdata2, op1, op2;
  logic              hz;
  logic              unused_inst;

  logic              ex_valid_q,    ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic              ex_memread_q,  ex_memread_d;
  logic              ex_regwrite_q, ex_regwrite_d;
  logic [AW-1:0]     ex_dest_q,     ex_dest_d;
  logic [AW-1:0]     ex_rs_q,       ex_rs_d;
  logic [AW-1:0]     ex_rt_q,       ex_rt_d;
  logic [XLEN-1:0]   ex_op1_q,      ex_op1_d;
  logic [XLEN-1:0]   ex_op2_q,      ex_op2_d;
  logic [XLEN-1:0]   ex_rdata2_q,   ex_rdata2_d;
  logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
  logic [CNT_W-1:0]  bubble_cnt_q,  bubble_cnt_d;

  assign rs          = bus.id_inst[RS_LSB +: AW];
  assign rt          = bus.id_inst[RT_LSB +: AW];
  assign unused_inst = ^bus.id_inst;

  regfile_bypass #(.XLEN(XLEN), .REGS(REGS), .AW(AW)) u_rf (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (bus.wb_we),
    .waddr_i  (bus.wb_addr),
    .wdata_i  (bus.wb_data),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign op1 = bus.dec_shift   ? XLEN'(bus.id_inst[SHAMT_LSB +: SHAMT_W]) : rdata1;
  assign op2 = bus.dec_imm_sel ? bus.dec_imm : rdata2;

  assign hz = bus.id_valid && ex_valid_q && ex_memread_q &&
              (ex_dest_q != AW'(ZERO_REG)) &&
              ((ex_dest_q == rs) || (bus.dec_uses_rt && (ex_dest_q == rt)));

  // Gated by reset so a downstream stall cannot freeze the front end while held in reset.
  assign bus.stall = reset && !bus.ex_flush && (bus.ext_stall || hz);

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_memread_d  = ex_memread_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_dest_d     = ex_dest_q;
    ex_rs_d       = ex_rs_q;
    ex_rt_d       = ex_rt_q;
    ex_op1_d      = ex_op1_q;
    ex_op2_d      = ex_op2_q;
    ex_rdata2_d   = ex_rdata2_q;
    ex_pc_d       = ex_pc_q;
    bubble_cnt_d  = bubble_cnt_q;

    if (bus.ex_flush) begin
      ex_valid_d    = 1'b0;
      ex_memread_d  = 1'b0;
      ex_regwrite_d = 1'b0;
    end else if (bus.ext_stall) begin
      // Whole ID/EX register holds.
    end else if (hz) begin
      ex_valid_d    = 1'b0;
      ex_memread_d  = 1'b0;
      ex_regwrite_d = 1'b0;
      bubble_cnt_d  = sat_inc(bubble_cnt_q);
    end else begin
      ex_valid_d    = bus.id_valid;
      ex_ctrl_d     = bus.dec_ctrl;
      ex_memread_d  = bus.dec_memread  && bus.id_valid;
      ex_regwrite_d = bus.dec_regwrite && bus.id_valid;
      ex_dest_d     = bus.dec_dest;
      ex_rs_d       = rs;
      ex_rt_d       = rt;
      ex_op1_d      = op1;
      ex_op2_d      = op2;
      ex_rdata2_d   = rdata2;
      ex_pc_d       = bus.id_pc;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_memread_q  <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_dest_q     <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_rdata2_q   <= '0;
      ex_pc_q       <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_memread_q  <= ex_memread_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_dest_q     <= ex_dest_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_op1_q      <= ex_op1_d;
      ex_op2_q      <= ex_op2_d;
      ex_rdata2_q   <= ex_rdata2_d;
      ex_pc_q       <= ex_pc_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_memread  = ex_memread_q;
  assign bus.ex_regwrite = ex_regwrite_q;
  assign bus.ex_dest     = ex_dest_q;
  assign bus.ex_rs       = ex_rs_q;
  assign bus.ex_rt       = ex_rt_q;
  assign bus.ex_op1      = ex_op1_q;
  assign bus.ex_op2      = ex_op2_q;
  assign bus.ex_rdata2   = ex_rdata2_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: bypass, zero register, load-use bubbles, stall/flush
// priority, counter saturation (CNT_W=2) and asynchronous reset.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(32), .REGS(32), .CTRL_W(8), .CNT_W(2)) bus ();

  id_stage_pipe #(.XLEN(32), .REGS(32), .CTRL_W(8), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input int rs, input int rt, input int sh);
    return ((32'(rs) & 32'h1f) << 21) | ((32'(rt) & 32'h1f) << 16) | ((32'(sh) & 32'h1f) << 6);
  endfunction

  task automatic drive_id(input logic v, input logic [31:0] pc, input int rs, input int rt,
                          input int sh, input logic [7:0] ctrl, input logic mr, input logic rw,
                          input logic urt, input logic shf, input logic isel,
                          input logic [31:0] imm, input int dest);
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_inst      = mk_inst(rs, rt, sh);
    bus.dec_ctrl     = ctrl;
    bus.dec_memread  = mr;
    bus.dec_regwrite = rw;
    bus.dec_uses_rt  = urt;
    bus.dec_shift    = shf;
    bus.dec_imm_sel  = isel;
    bus.dec_imm      = imm;
    bus.dec_dest     = 5'(dest);
  endtask

  initial begin
    reset = 1'b0;
    drive_id(1'b0, 32'h0, 0, 0, 0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ex_flush = 1'b0; bus.ext_stall = 1'b1;
    #3;
    chk("rst_stall", bus.stall, 0);
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_pc", bus.ex_pc, 0);
    chk("rst_cnt", bus.bubble_cnt, 0);
    bus.ext_stall = 1'b0;
    #9 reset = 1'b1;
    step();

    // Write-through bypass and register-file hold
    bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    drive_id(1'b1, 32'h100, 5, 0, 0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 7);
    step();
    chk("bypass_op1", bus.ex_op1, 32'hDEADBEEF);
    chk("imm_op2", bus.ex_op2, 32'h55);
    chk("ld_valid", bus.ex_valid, 1);
    chk("ld_regwrite", bus.ex_regwrite, 1);
    chk("ld_ctrl", bus.ex_ctrl, 8'hA5);
    chk("ld_pc", bus.ex_pc, 32'h100);
    chk("ld_rs", bus.ex_rs, 5);
    chk("ld_dest", bus.ex_dest, 7);
    bus.wb_we = 1'b0;
    drive_id(1'b1, 32'h104, 5, 0, 0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 7);
    step();
    chk("rf_hold_op1", bus.ex_op1, 32'hDEADBEEF);
    chk("rt0_op2", bus.ex_op2, 0);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
    drive_id(1'b1, 32'h108, 0, 0, 0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 7);
    step();
    chk("r0_bypass", bus.ex_op1, 0);
    bus.wb_we = 1'b0;
    step();
    chk("r0_read", bus.ex_op1, 0);
    drive_id(1'b1, 32'h10C, 5, 5, 9, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 7);
    step();
    chk("shamt_op1", bus.ex_op1, 9);
    chk("rt_op2", bus.ex_op2, 32'hDEADBEEF);
    chk("rdata2", bus.ex_rdata2, 32'hDEADBEEF);
    chk("ld_rt", bus.ex_rt, 5);

    // Load-use on rs: one bubble, then issue with r3 bypassed from WB
    drive_id(1'b1, 32'h200, 0, 0, 0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3);
    step();
    chk("load_memread", bus.ex_memread, 1);
    chk("load_dest", bus.ex_dest, 3);
    drive_id(1'b1, 32'h204, 3, 0, 0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8);
    #1 chk("hz_stall", bus.stall, 1);
    step();
    chk("bubble_valid", bus.ex_valid, 0);
    chk("bubble_memread", bus.ex_memread, 0);
    chk("bubble_cnt1", bus.bubble_cnt, 1);
    chk("hz_drop", bus.stall, 0);
    bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hCAFE0003;
    step();
    bus.wb_we = 1'b0;
    chk("issue_valid", bus.ex_valid, 1);
    chk("issue_op1", bus.ex_op1, 32'hCAFE0003);
    chk("issue_pc", bus.ex_pc, 32'h204);
    chk("issue_dest", bus.ex_dest, 8);

    // No hazard when rt is not a source or the load targets r0
    drive_id(1'b1, 32'h300, 0, 0, 0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3);
    step();
    drive_id(1'b1, 32'h304, 0, 3, 0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 9);
    #1 chk("no_hz_imm", bus.stall, 0);
    bus.dec_uses_rt = 1'b1;
    #1 chk("hz_rt", bus.stall, 1);
    bus.dec_uses_rt = 1'b0;
    step();
    chk("imm_issue_valid", bus.ex_valid, 1);
    chk("imm_cnt", bus.bubble_cnt, 1);
    drive_id(1'b1, 32'h308, 0, 0, 0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    step();
    drive_id(1'b1, 32'h30C, 0, 0, 0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4);
    #1 chk("no_hz_r0", bus.stall, 0);
    step();

    // Downstream stall freezes ID/EX for three cycles
    drive_id(1'b1, 32'h400, 5, 0, 0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 9);
    step();
    drive_id(1'b1, 32'h404, 5, 0, 0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 10);
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ext_stall_out", bus.stall, 1);
      step();
      chk("hold_pc", bus.ex_pc, 32'h400);
      chk("hold_ctrl", bus.ex_ctrl, 8'h3C);
      chk("hold_dest", bus.ex_dest, 9);
    end
    bus.ext_stall = 1'b0;
    step();
    chk("release_pc", bus.ex_pc, 32'h404);
    chk("release_ctrl", bus.ex_ctrl, 8'h11);

    // Flush beats ext_stall and hz
    drive_id(1'b1, 32'h500, 0, 0, 0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3);
    step();
    drive_id(1'b1, 32'h504, 3, 0, 0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6);
    bus.ext_stall = 1'b1; bus.ex_flush = 1'b1;
    #1 chk("flush_stall", bus.stall, 0);
    step();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_regwrite", bus.ex_regwrite, 0);
    chk("flush_memread", bus.ex_memread, 0);
    chk("flush_cnt", bus.bubble_cnt, 1);
    bus.ext_stall = 1'b0; bus.ex_flush = 1'b0;

    // Five more bubbles: 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      drive_id(1'b1, 32'h600, 0, 0, 0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3);
      step();
      drive_id(1'b1, 32'h604, 3, 0, 0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6);
      step();
      chk("sat_cnt", bus.bubble_cnt, (k + 2 > 3) ? 3 : k + 2);
    end

    // Asynchronous reset mid-stream, then first edge is a normal load
    drive_id(1'b1, 32'h700, 5, 0, 0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 12);
    step();
    chk("pre_rst_valid", bus.ex_valid, 1);
    #2 reset = 1'b0; bus.ext_stall = 1'b1;
    #1;
    chk("arst_valid", bus.ex_valid, 0);
    chk("arst_pc", bus.ex_pc, 0);
    chk("arst_ctrl", bus.ex_ctrl, 0);
    chk("arst_regwrite", bus.ex_regwrite, 0);
    chk("arst_cnt", bus.bubble_cnt, 0);
    chk("arst_stall", bus.stall, 0);
    bus.ext_stall = 1'b0;
    #3 reset = 1'b1;
    step();
    chk("post_rst_valid", bus.ex_valid, 1);
    chk("post_rst_rf", bus.ex_op1, 0);
    chk("post_rst_pc", bus.ex_pc, 32'h700);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
